// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared constants for the button front end and the game top: channel count,
// debounce and lockout defaults, and a width helper for the per-channel and
// lockout counters.
// No ports (package).
// -----------------------------------------------------------------------------
package button_pkg;

   // Number of button channels on the board.
   localparam int unsigned BTN_WIDTH           = 8;

   // Default debounce qualification window in clk cycles.
   localparam int unsigned BTN_DEBOUNCE_CYCLES = 500000;

   // Default post-press suppression window in clk cycles.
   localparam int unsigned BTN_LOCKOUT_CYCLES  = 2500000;

   // Legal parameter limits.
   localparam int unsigned BTN_DEBOUNCE_MIN    = 2;
   localparam int unsigned BTN_DEBOUNCE_MAX    = 32'd1 << 20;
   localparam int unsigned BTN_LOCKOUT_MIN     = 1;
   localparam int unsigned BTN_LOCKOUT_MAX     = 32'd1 << 24;

   // ceil(log2(n)), never below 1 so every counter has at least one bit.
   function automatic int unsigned cnt_bits(input int unsigned n);
      int unsigned bits;
      bits = $clog2(n);
      if (bits < 1) bits = 1;
      return bits;
   endfunction

endpackage : button_pkg

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One button channel: 2-flop synchronizer, qualification counter and the
// debounced level register. A level change is accepted once the synchronized
// input has differed from the level for DEBOUNCE_CYCLES consecutive cycles;
// any cycle where they agree clears the counter, so a bounce restarts the
// qualification from zero.
//
// Ports
//   clk     in   sole clock, rising edge
//   reset   in   asynchronous, active-low reset
//   button  in   raw asynchronous button, 1 = pressed
//   level   out  debounced registered level
//   rise    out  high in the cycle a 0->1 change is being accepted, i.e. the
//                same edge that loads level with 1 (decoded from flops only)
// -----------------------------------------------------------------------------
module debounce_bit
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES
)
(
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic level,
   output logic rise
);

   localparam int unsigned   CW   = cnt_bits(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          qualify;

   if ((DEBOUNCE_CYCLES < BTN_DEBOUNCE_MIN) || (DEBOUNCE_CYCLES > BTN_DEBOUNCE_MAX)) begin : g_bad_debounce
      $error("debounce_bit: DEBOUNCE_CYCLES out of range 2..2^20");
   end

   // Two-stage synchronizer; nothing else looks at the raw button.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= button;
         sync <= meta;
      end
   end

   assign differ  = sync ^ level;
   // Counter value LAST means this is the DEBOUNCE_CYCLES-th differing cycle.
   assign qualify = differ && (cnt == LAST);
   assign rise    = qualify & sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (!differ) begin
         cnt   <= '0;
      end else if (qualify) begin
         level <= sync;
         cnt   <= '0;
      end else begin
         cnt   <= cnt + CW'(1);
      end
   end

endmodule : debounce_bit

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions WIDTH raw mechanical buttons for the mole/LED scoring stage:
// each channel is synchronized and debounced in its own debounce_bit, and a
// registered one-cycle press pulse is produced in the first cycle a channel's
// debounced level reads 1. Releases never pulse.
//
// Optional feature (macro BTN_LOCKOUT_EN):
//   After any emitted pulse a lockout counter is loaded with LOCKOUT_CYCLES
//   and all press pulses are suppressed while it is nonzero. Presses that
//   qualify during lockout are dropped, never delivered late. When several
//   channels qualify in the same cycle only the lowest index pulses.
//   Without the macro there is no lockout counter, LOCKOUT_CYCLES is only
//   range-checked, and every qualifying channel pulses independently.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-low reset
//   button     in   [WIDTH] raw asynchronous buttons, 1 = pressed
//   btn_level  out  [WIDTH] debounced registered level per channel
//   btn_press  out  [WIDTH] registered one-cycle press pulse per channel
// -----------------------------------------------------------------------------
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned WIDTH           = BTN_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
   parameter int unsigned LOCKOUT_CYCLES  = BTN_LOCKOUT_CYCLES
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] button,
   output logic [WIDTH-1:0] btn_level,
   output logic [WIDTH-1:0] btn_press
);

   // Per-channel "accepting a press this edge" flags, decoded from flops.
   logic [WIDTH-1:0] rise;

   if ((LOCKOUT_CYCLES < BTN_LOCKOUT_MIN) || (LOCKOUT_CYCLES > BTN_LOCKOUT_MAX)) begin : g_bad_lockout
      $error("button_conditioner: LOCKOUT_CYCLES out of range 1..2^24");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .button (button[i]),
         .level  (btn_level[i]),
         .rise   (rise[i])
      );
   end

`ifdef BTN_LOCKOUT_EN

   // Wide enough to hold LOCKOUT_CYCLES itself.
   localparam int unsigned      LW  = cnt_bits(LOCKOUT_CYCLES + 1);
   localparam logic [LW-1:0]    LOCK_LOAD = LW'(LOCKOUT_CYCLES);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [LW-1:0]    lock_cnt;
   logic [WIDTH-1:0] press_next;

   // Two's-complement trick isolates the lowest set bit of rise.
   always_comb begin
      press_next = '0;
      if (lock_cnt == '0) begin
         press_next = rise & (~rise + ONE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_press <= '0;
         lock_cnt  <= '0;
      end else begin
         btn_press <= press_next;
         if (press_next != '0) begin
            lock_cnt <= LOCK_LOAD;
         end else if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LW'(1);
         end
      end
   end

`else

   // Channels are independent: every qualifying channel pulses together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_press <= '0;
      end else begin
         btn_press <= rise;
      end
   end

`endif

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with WIDTH=8, DEBOUNCE_CYCLES=4,
// LOCKOUT_CYCLES=10. A table of {button, expected level, expected press}
// records is applied one per clock, followed by hand-written reset sequences.
// Expected pulse patterns for simultaneous presses follow BTN_LOCKOUT_EN.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int unsigned W = 8;

   logic         clk;
   logic         reset;
   logic [W-1:0] button;
   logic [W-1:0] btn_level;
   logic [W-1:0] btn_press;

   typedef struct {
      logic [W-1:0] button;
      logic [W-1:0] level;
      logic [W-1:0] press;
   } vec_t;

   vec_t vecs[$];

   int n_vec;
   int n_miss;

   button_conditioner #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (4),
      .LOCKOUT_CYCLES  (10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .button    (button),
      .btn_level (btn_level),
      .btn_press (btn_press)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic void add(input logic [W-1:0] b, input logic [W-1:0] l,
                               input logic [W-1:0] p);
      vec_t v;
      v.button = b;
      v.level  = l;
      v.press  = p;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic [W-1:0] b);
      @(negedge clk);
      button = b;
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] p81;
      logic [W-1:0] p08;

      n_vec  = 0;
      n_miss = 0;
      reset  = 1'b0;
      button = '0;

`ifdef BTN_LOCKOUT_EN
      p81 = 8'h01;
      p08 = 8'h00;
`else
      p81 = 8'h81;
      p08 = 8'h08;
`endif

      // Single press on channel 2: level and pulse at the 6th edge.
      for (int i = 0; i < 5; i++) add(8'h04, 8'h00, 8'h00);
      add(8'h04, 8'h04, 8'h04);
      add(8'h04, 8'h04, 8'h00);
      // Release of channel 2: level drops at the 6th edge, never a pulse.
      for (int i = 0; i < 5; i++) add(8'h00, 8'h04, 8'h00);
      add(8'h00, 8'h00, 8'h00);
      add(8'h00, 8'h00, 8'h00);
      // Bounce on channel 0: 1,0,1 then hold; accepted 6 edges after last rise.
      add(8'h01, 8'h00, 8'h00);
      add(8'h00, 8'h00, 8'h00);
      add(8'h01, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) add(8'h01, 8'h00, 8'h00);
      add(8'h01, 8'h01, 8'h01);
      add(8'h01, 8'h01, 8'h00);
      for (int i = 0; i < 5; i++) add(8'h00, 8'h01, 8'h00);
      add(8'h00, 8'h00, 8'h00);
      // Channels 0 and 7 together, then channel 3 five cycles after the pulse.
      for (int i = 0; i < 5; i++) add(8'h81, 8'h00, 8'h00);
      add(8'h81, 8'h81, p81);
      for (int i = 0; i < 4; i++) add(8'h81, 8'h81, 8'h00);
      for (int i = 0; i < 5; i++) add(8'h89, 8'h81, 8'h00);
      add(8'h89, 8'h89, p08);
      for (int i = 0; i < 5; i++) add(8'h89, 8'h89, 8'h00);

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_level", btn_level, 8'h00);
      check("reset_press", btn_press, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      // Table.
      foreach (vecs[k]) begin
         step(vecs[k].button);
         check($sformatf("vec%0d_level", k + 1), btn_level, vecs[k].level);
         check($sformatf("vec%0d_press", k + 1), btn_press, vecs[k].press);
      end

      // Release everything.
      for (int i = 0; i < 8; i++) step(8'h00);
      check("idle_level", btn_level, 8'h00);
      check("idle_press", btn_press, 8'h00);

      // Reset asserted mid-qualification after edge 3, button released in reset.
      for (int i = 0; i < 3; i++) step(8'h02);
      reset = 1'b0;
      #1;
      check("midq_rst_level", btn_level, 8'h00);
      check("midq_rst_press", btn_press, 8'h00);
      step(8'h00);
      step(8'h00);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step(8'h00);
         check($sformatf("midq_after%0d_level", k), btn_level, 8'h00);
         check($sformatf("midq_after%0d_press", k), btn_press, 8'h00);
      end

      // Button held through reset deassertion: press at the 6th edge.
      step(8'h02);
      reset = 1'b0;
      step(8'h02);
      step(8'h02);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("held_e%0d_level", k), btn_level, (k >= 6) ? 8'h02 : 8'h00);
         check($sformatf("held_e%0d_press", k), btn_press, (k == 6) ? 8'h02 : 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_button_conditioner
